// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for a 5-stage RISC-V pipeline: load-use, branch redirect
// and data-memory wait handling, plus saturating stall/flush counters and a wait timeout flag.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ifid_rs1_i,
  input  logic [4:0]       ifid_rs2_i,
  input  logic [4:0]       idex_rd_i,
  input  logic             idex_memread_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             ifid_flush_o,
  output logic             idex_en_o,
  output logic             idex_flush_o,
  output logic             exmem_en_o,
  output logic             memwb_bubble_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic ST_RUN      = 1'b0;
  localparam logic ST_MEM_WAIT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [15:0]      WAIT_MAX = '1;
  localparam logic [15:0]      WAIT_LIM = 16'(MEM_TIMEOUT);

  logic             state_reg, state_next;
  logic [15:0]      wait_cnt_reg, wait_cnt_next;
  logic             mem_err_reg;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  logic mem_stall;
  logic load_use;
  logic branch_flush;

  assign mem_stall = dmem_req_i & ~dmem_ready_i;
  assign load_use  = idex_memread_i & (idex_rd_i != 5'd0) &
                     ((idex_rd_i == ifid_rs1_i) | (idex_rd_i == ifid_rs2_i));
  assign branch_flush = ~rst_i & ~mem_stall & branch_taken_i;

  always_comb begin
    pc_en_o        = 1'b1;
    ifid_en_o      = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_en_o      = 1'b1;
    idex_flush_o   = 1'b0;
    exmem_en_o     = 1'b1;
    memwb_bubble_o = 1'b0;
    if (rst_i) begin
      pc_en_o        = 1'b0;
      ifid_en_o      = 1'b0;
      idex_en_o      = 1'b0;
      exmem_en_o     = 1'b0;
      ifid_flush_o   = 1'b1;
      idex_flush_o   = 1'b1;
      memwb_bubble_o = 1'b1;
    end else if (mem_stall) begin
      pc_en_o        = 1'b0;
      ifid_en_o      = 1'b0;
      idex_en_o      = 1'b0;
      exmem_en_o     = 1'b0;
      memwb_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      // Squashing the ID instruction also removes any load-use dependency it had.
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
    end else if (load_use) begin
      pc_en_o      = 1'b0;
      ifid_en_o    = 1'b0;
      idex_flush_o = 1'b1;
    end
  end

  // The wait counter holds the number of stalled memory cycles so far, the entry cycle included.
  always_comb begin
    state_next    = mem_stall ? ST_MEM_WAIT : ST_RUN;
    wait_cnt_next = wait_cnt_reg;
    if (mem_stall) begin
      if (state_reg == ST_RUN)
        wait_cnt_next = 16'd1;
      else if (wait_cnt_reg != WAIT_MAX)
        wait_cnt_next = wait_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= ST_RUN;
      wait_cnt_reg  <= 16'd0;
      mem_err_reg   <= 1'b0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (mem_stall && (wait_cnt_next >= WAIT_LIM))
        mem_err_reg <= 1'b1;
      if (!pc_en_o && (stall_cnt_reg != CNT_MAX))
        stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
      if (branch_flush && (flush_cnt_reg != CNT_MAX))
        flush_cnt_reg <= flush_cnt_reg + CNT_ONE;
    end
  end

  assign mem_err_o   = mem_err_reg;
  assign stall_cnt_o = stall_cnt_reg;
  assign flush_cnt_o = flush_cnt_reg;

endmodule
